wb_drain_ctrl: RTL and testbench
================================

# wb_drain_ctrl

Write-buffer drain controller: the read-side master of the address/data write FIFO between the data cache and main memory. Pops one address/data entry at a time from the FIFO, holds it stable, and issues it to the memory port as a write request with a req/ack handshake. Also provides flush completion signalling, a read-after-write hazard check against the in-flight entry, a sticky timeout error and a drained-entry counter.

## Interface
- ADDRESS_WIDTH, 32: width of FIFO address and memory address.
- DATA_WIDTH, 128: width of FIFO data and memory write data (one cache line).
- TIMEOUT, 255: maximum REQ cycles without ack before the entry is dropped; legal range 1..65535.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag (registered inside FIFO).
- fifo_rd_en  out  1  FIFO pop strobe.
- fifo_address_out  in  ADDRESS_WIDTH  FIFO read address, valid the cycle after the pop edge.
- fifo_data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after the pop edge.
- mem_req  out  1  memory write request.
- mem_addr  out  ADDRESS_WIDTH  memory write address (hold register).
- mem_wdata  out  DATA_WIDTH  memory write data (hold register).
- mem_ack  in  1  memory write accepted.
- flush_req  in  1  flush request pulse/level.
- flush_done  out  1  one-cycle pulse: flush complete.
- chk_addr  in  ADDRESS_WIDTH  address probed by the load path.
- chk_hit  out  1  chk_addr matches the in-flight entry.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky: an entry was dropped on timeout.
- drain_count  out  16  entries acknowledged by memory, wraps modulo 2^16.

## Operation
- States: IDLE, POP, CAPT, REQ. Outputs are Moore-decoded from state or registered.
- IDLE: if !fifo_empty -> POP; else stay.
- POP: fifo_rd_en=1 for exactly this cycle -> CAPT unconditionally.
- CAPT: fifo_address_out/fifo_data_out loaded into hold regs at the end of CAPT -> REQ. FIFO outputs read zero outside the cycle after a pop; capture happens only in CAPT.
- REQ: mem_req=1, mem_addr/mem_wdata stable. mem_ack sampled high -> IDLE, drain_count+1. Otherwise timer+1; timer == TIMEOUT-1 with no ack -> err_timeout<=1, entry dropped, -> IDLE. Timer clears on entering REQ.
- mem_ack outside REQ is ignored.
- chk_hit = (state==REQ) && (chk_addr==mem_addr), combinational, full-width compare.
- Flush: flush_req high in any cycle sets flush_pending. flush_done pulses for one cycle when flush_pending && state==IDLE && fifo_empty; flush_pending clears on the same edge. A flush_req arriving in the flush_done cycle re-arms flush_pending.
- err_timeout is cleared only by rst.

## Timing
- Reset values: state IDLE, fifo_rd_en 0, mem_req 0, mem_addr 0, mem_wdata 0, flush_done 0, busy 0, err_timeout 0, drain_count 0, flush_pending 0, timer 0.
- Cycle t IDLE with fifo_empty=0 -> t+1 POP -> t+2 CAPT -> t+3 first mem_req cycle.
- Ack in cycle k (REQ) -> mem_req=0 at k+1 (IDLE).
- Minimum per-entry period: 4 cycles with ack on the first REQ cycle.
- fifo_empty lags the FIFO count by one cycle. After POP it is next sampled in IDLE, at least 2 cycles later, so it is accurate; no double pop.
- rst mid-operation: at the next edge all outputs take their reset values. An in-flight entry is lost. The memory side must tolerate mem_req falling without ack.

## Test plan
- Single entry: FIFO holds {addr 0x1000, data 0xA5..A5}. Ack on the 2nd REQ cycle -> fifo_rd_en 1 cycle; mem_req from t+3 for 2 cycles with addr 0x1000 and data unchanged; drain_count=1.
- Back-to-back: 3 entries 0x10/0x20/0x30 with ack latency 0 then 5 -> three requests in FIFO order, no duplicated or skipped entry, mem_addr stable across every wait cycle, drain_count=3.
- Timeout: TIMEOUT=8, mem_ack tied 0 -> mem_req high exactly 8 cycles; err_timeout=1 and stays 1; next entry still drained once ack is re-enabled.
- Flush: 2 entries queued, flush_req pulsed in cycle 0 -> flush_done exactly one cycle, after the 2nd ack and the IDLE+empty cycle. No flush_done earlier.
- Hazard: entry 0x2040 in REQ; chk_addr=0x2040 -> chk_hit=1; chk_addr=0x2044 -> 0; chk_addr=0x2040 during POP/CAPT/IDLE -> 0.
- Reset in REQ: rst high 1 cycle -> next cycle mem_req=0, busy=0, drain_count=0, err_timeout=0, mem_addr=0.

Source files
------------

// File: rtl/wb_drain_ctrl.sv
// wb_drain_ctrl
// Write-buffer drain controller. It is the read-side master of the
// address/data write FIFO that sits between the data cache and main memory.
// It pops one entry at a time and holds the address and data stable. It then
// issues the entry to the memory port as a write request, using a req/ack
// handshake. It also signals flush completion, checks read-after-write hazards
// against the in-flight entry, raises a sticky timeout error and counts drained
// entries.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   fifo_empty          FIFO empty flag (registered in the FIFO, one cycle lag)
//   fifo_rd_en          FIFO pop strobe (high for exactly the POP cycle)
//   fifo_address_out    FIFO read address, valid the cycle after a pop
//   fifo_data_out       FIFO read data, valid the cycle after a pop
//   mem_req             memory write request (high throughout REQ)
//   mem_addr/mem_wdata  hold registers presented to memory
//   mem_ack             memory accepted the write (only looked at in REQ)
//   flush_req           flush request, pulse or level
//   flush_done          one-cycle pulse: pending flush has completed
//   chk_addr/chk_hit    load-path probe against the in-flight entry
//   busy                controller is not idle
//   err_timeout         sticky: an entry was dropped after TIMEOUT REQ cycles
//   drain_count         entries acknowledged by memory, modulo 2^16
module wb_drain_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [ADDRESS_WIDTH-1:0] fifo_address_out,
  input  logic [DATA_WIDTH-1:0]    fifo_data_out,
  output logic                     mem_req,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic                     flush_req,
  output logic                     flush_done,
  input  logic [ADDRESS_WIDTH-1:0] chk_addr,
  output logic                     chk_hit,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [15:0]              drain_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    REQ  = 2'd3
  } state_t;

  // Last REQ cycle index before the entry is given up (timer counts from 0).
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [15:0]              timer_q, timer_d;
  logic [15:0]              count_q, count_d;
  logic                     err_q, err_d;
  logic                     flush_pend_q, flush_pend_d;
  logic                     flush_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      timer_q      <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      err_q        <= err_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    timer_d = timer_q;
    count_d = count_q;
    err_d   = err_q;

    unique case (state_q)
      // fifo_empty is only looked at here; at least two cycles have passed
      // since the previous pop, so its one-cycle lag cannot cause a double pop.
      IDLE: begin
        if (!fifo_empty) state_d = POP;
      end
      POP: begin
        state_d = CAPT;
      end
      // FIFO outputs are only meaningful in this cycle, so capture here.
      CAPT: begin
        addr_d  = fifo_address_out;
        data_d  = fifo_data_out;
        timer_d = '0;
        state_d = REQ;
      end
      REQ: begin
        if (mem_ack) begin
          count_d = count_q + 16'd1;
          state_d = IDLE;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A new flush_req wins over the clear, so a request landing in the
  // flush_done cycle re-arms the pending flag.
  always_comb begin
    flush_fire   = flush_pend_q && (state_q == IDLE) && fifo_empty;
    flush_pend_d = flush_req || (flush_pend_q && !flush_fire);
  end

  assign fifo_rd_en  = (state_q == POP);
  assign mem_req     = (state_q == REQ);
  assign busy        = (state_q != IDLE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = data_q;
  assign err_timeout = err_q;
  assign drain_count = count_q;
  assign flush_done  = flush_fire;
  assign chk_hit     = (state_q == REQ) && (chk_addr == addr_q);

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// tb_wb_drain_ctrl
// Bench for wb_drain_ctrl. It contains a FIFO model and a memory responder
// that drive the DUT. A scoreboard queue holds every entry handed to the DUT,
// together with the ack latency chosen for it. A monitor on the falling edge
// retires requests against that queue. It also tracks the drain count, the
// timeout flag, flush completion and the hazard probe.
module tb_wb_drain_ctrl;

  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [AW-1:0] fifo_address_out = '0;
  logic [DW-1:0] fifo_data_out = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic [AW-1:0] chk_addr = '0;
  logic          chk_hit;
  logic          busy;
  logic          err_timeout;
  logic [15:0]   drain_count;

  always #5 clk = ~clk;

  wb_drain_ctrl #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .TIMEOUT      (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_empty      (fifo_empty),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_address_out(fifo_address_out),
    .fifo_data_out   (fifo_data_out),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .flush_req       (flush_req),
    .flush_done      (flush_done),
    .chk_addr        (chk_addr),
    .chk_hit         (chk_hit),
    .busy            (busy),
    .err_timeout     (err_timeout),
    .drain_count     (drain_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            lat;   // REQ cycles before ack; >= TMO means never ack
  } ent_t;

  ent_t fifo_q[$];   // entries still in the FIFO
  ent_t exp_q[$];    // entries popped by the DUT, awaiting their request

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void checkw(string name, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void check1(string name, logic got, logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endfunction

  // ---------------- FIFO model and memory responder ----------------
  ent_t stage;
  bit   stage_v   = 1'b0;
  int   prev_size = 0;
  int   rcyc      = 0;

  always @(posedge clk) begin
    int r;
    #1;
    if (stage_v) begin
      fifo_address_out = stage.addr;
      fifo_data_out    = stage.data;
      stage_v          = 1'b0;
    end else begin
      fifo_address_out = '0;
      fifo_data_out    = '0;
    end
    if (fifo_rd_en) begin
      check1("pop_nonempty", fifo_q.size() != 0, 1'b1);
      if (fifo_q.size() != 0) begin
        stage   = fifo_q.pop_front();
        stage_v = 1'b1;
        exp_q.push_back(stage);
      end
    end
    // Empty flag reflects the occupancy of one cycle earlier.
    fifo_empty = (prev_size == 0);
    prev_size  = fifo_q.size();

    if (mem_req) begin
      rcyc++;
      mem_ack = (exp_q.size() != 0) && (rcyc - 1 == exp_q[0].lat);
    end else begin
      rcyc    = 0;
      mem_ack = 1'($urandom_range(0, 1));
    end

    r = int'($urandom_range(0, 3));
    if (exp_q.size() != 0 && r < 2)       chk_addr = exp_q[0].addr;
    else if (exp_q.size() != 0 && r == 2) chk_addr = exp_q[0].addr + 32'd4;
    else                                  chk_addr = $urandom;
  end

  // ---------------- monitor / scoreboard ----------------
  int   cyc       = 0;
  int   rd_cyc    = -100;
  int   ncyc      = 0;
  bit   active    = 1'b0;
  ent_t cur;
  int   model_cnt = 0;
  bit   model_err = 1'b0;
  bit   pend      = 1'b0;
  bit   want_pop  = 1'b0;
  bit   idle_m;
  bit   exp_fd;
  int   fd_count  = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      active    = 1'b0;
      model_cnt = 0;
      model_err = 1'b0;
      pend      = 1'b0;
      want_pop  = 1'b0;
    end else begin
      check1("fifo_rd_en", fifo_rd_en, want_pop);
      if (fifo_rd_en) rd_cyc = cyc;
      if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          ncyc   = 0;
          check1("req_has_entry", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) cur = exp_q[0];
          checkw("req_start_after_pop", 128'(cyc - rd_cyc), 128'(2));
        end
        ncyc++;
        checkw("mem_addr", 128'(mem_addr), 128'(cur.addr));
        checkw("mem_wdata", mem_wdata, cur.data);
        check1("chk_hit_req", chk_hit, chk_addr == cur.addr);
      end else begin
        check1("chk_hit_not_req", chk_hit, 1'b0);
        if (active) begin
          checkw("req_cycles", 128'(ncyc), 128'((cur.lat < TMO) ? cur.lat + 1 : TMO));
          if (cur.lat < TMO) model_cnt = (model_cnt + 1) % 65536;
          else               model_err = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          active = 1'b0;
        end
      end
      checkw("drain_count", 128'(drain_count), 128'(model_cnt));
      check1("err_timeout", err_timeout, model_err);
      idle_m = !active && (exp_q.size() == 0);
      check1("busy", busy, !idle_m);
      exp_fd = pend && idle_m && fifo_empty;
      check1("flush_done", flush_done, exp_fd);
      if (flush_done) fd_count++;
      pend     = flush_req || (pend && !exp_fd);
      want_pop = idle_m && !fifo_empty;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat);
    ent_t e;
    e.addr = a;
    e.data = d;
    e.lat  = lat;
    fifo_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !active && !stage_v) begin
        done = 1'b1;
        break;
      end
    end
    check1("drain_within_budget", done, 1'b1);
    tick(2);
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
  endtask

  initial begin
    int fd0;
    bit seen;
    logic [DW-1:0] d;

    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check1("rst_fifo_rd_en", fifo_rd_en, 1'b0);
    check1("rst_mem_req", mem_req, 1'b0);
    checkw("rst_mem_addr", 128'(mem_addr), 128'(0));
    checkw("rst_mem_wdata", mem_wdata, 128'(0));
    check1("rst_flush_done", flush_done, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_err_timeout", err_timeout, 1'b0);
    checkw("rst_drain_count", 128'(drain_count), 128'(0));

    // Single entry, ack on the second REQ cycle.
    push(32'h1000, {16{8'hA5}}, 1);
    wait_drain(50);
    checkw("single_count", 128'(drain_count), 128'(1));

    // Back-to-back entries with differing ack latency.
    push(32'h10, 128'h1111, 0);
    push(32'h20, 128'h2222, 5);
    push(32'h30, 128'h3333, 0);
    wait_drain(100);
    checkw("b2b_count", 128'(drain_count), 128'(4));

    // Hazard probe entry.
    push(32'h2040, 128'h2040_2040, 6);
    wait_drain(50);
    checkw("hazard_count", 128'(drain_count), 128'(5));

    // Timeout: no ack for the first entry, the next one still drains.
    push(32'h40, 128'h4444, 200);
    push(32'h50, 128'h5555, 2);
    wait_drain(100);
    check1("timeout_err", err_timeout, 1'b1);
    checkw("timeout_count", 128'(drain_count), 128'(6));

    // Flush with two entries queued: exactly one completion pulse.
    fd0 = fd_count;
    push(32'h60, 128'h6666, 1);
    push(32'h70, 128'h7777, 3);
    tick(2);
    pulse_flush();
    wait_drain(100);
    tick(3);
    checkw("flush_pulses", 128'(fd_count - fd0), 128'(1));

    // Flush while already idle and empty.
    fd0 = fd_count;
    pulse_flush();
    tick(3);
    checkw("flush_idle_pulses", 128'(fd_count - fd0), 128'(1));

    // Randomized traffic with occasional flushes and timeouts.
    for (int i = 0; i < 40; i++) begin
      tick(int'($urandom_range(0, 6)));
      d = {$urandom, $urandom, $urandom, $urandom};
      push($urandom, d, int'($urandom_range(0, 11)));
      if ($urandom_range(0, 7) == 0) pulse_flush();
    end
    wait_drain(3000);
    check1("err_sticky", err_timeout, 1'b1);

    // Reset while a request is outstanding.
    push(32'h3000, 128'h3000, 200);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check1("rstreq_reached_req", seen, 1'b1);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check1("rstreq_mem_req", mem_req, 1'b0);
    check1("rstreq_busy", busy, 1'b0);
    checkw("rstreq_drain_count", 128'(drain_count), 128'(0));
    check1("rstreq_err_timeout", err_timeout, 1'b0);
    checkw("rstreq_mem_addr", 128'(mem_addr), 128'(0));

    push(32'h3100, 128'h3100, 0);
    wait_drain(50);
    checkw("post_rst_count", 128'(drain_count), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
